// File: rtl/mips_pipeline.sv
// Five-stage MIPS-subset core (IF/ID/EX/MEM/WB) with on-chip IMEM/DMEM, register file and debug hooks.
// Optional macro FORWARDING_EN adds EX and ID bypassing; without it ID stalls until producers reach WB.
module mips_pipeline #(
  parameter int ADDRWIDTH = 8
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic [31:0]          i_inst_load,
  input  logic [ADDRWIDTH-1:0] i_addr_inst_load,
  input  logic                 i_en_write,
  input  logic                 i_en_read,
  input  logic                 i_enable_mem,
  input  logic                 i_read_du,
  input  logic                 i_enable_pipe,
  input  logic                 i_debug_unit,
  input  logic [ADDRWIDTH-1:0] i_addr_debug_unit,
  input  logic [ADDRWIDTH-1:0] i_addr_mem_debug_unit,
  input  logic                 i_ctrl_read_debug_reg,
  input  logic                 i_ctrl_wr_debug_mem,
  input  logic                 i_ctrl_addr_debug_mem,
  output logic                 o_bit_sucio,
  output logic [ADDRWIDTH-1:0] o_data_send_pc,
  output logic [31:0]          o_data_reg_debug_unit,
  output logic [31:0]          o_data_mem_debug_unit,
  output logic [ADDRWIDTH-1:0] o_count_cycles,
  output logic                 o_halt
);
  localparam int DEPTH = 1 << ADDRWIDTH;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;
  localparam logic [5:0] FN_ADDU  = 6'h21;

  typedef struct packed {
    logic [31:0]          instr;
    logic [ADDRWIDTH-1:0] pc;
  } ifid_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        halt;
    logic        is_lui;
    logic        use_imm;
    logic [4:0]  dest;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } idex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        halt;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] store;
  } exmem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        halt;
    logic [4:0]  dest;
    logic [31:0] alu;
  } memwb_t;

  logic [31:0] imem [DEPTH];
  logic [31:0] dmem [DEPTH];
  logic [31:0] regs_q [32];
  logic [DEPTH-1:0] dirty_q;

  ifid_t  ifid_q, ifid_d;
  idex_t  idex_q, idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;
  logic [ADDRWIDTH-1:0] pc_q, pc_d, count_q, count_d;
  logic halt_q, halt_d, halt_fetch_q, halt_fetch_d;
  logic [31:0] load_data_q, reg_dbg_q, mem_dbg_q;

  logic adv;
  assign adv = i_enable_pipe & ~i_debug_unit & ~halt_q;

  // Writeback
  logic        wb_active, wb_we;
  logic [31:0] wb_data;
  assign wb_data   = memwb_q.mem_read ? load_data_q : memwb_q.alu;
  assign wb_active = memwb_q.reg_write && (memwb_q.dest != 5'd0);
  assign wb_we     = adv && wb_active;

  // Decode
  logic [31:0] id_instr, id_imm;
  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  assign id_instr = ifid_q.instr;
  assign id_op    = id_instr[31:26];
  assign id_rs    = id_instr[25:21];
  assign id_rt    = id_instr[20:16];
  assign id_rd    = id_instr[15:11];
  assign id_funct = id_instr[5:0];
  assign id_imm   = {{16{id_instr[15]}}, id_instr[15:0]};

  logic dec_reg_write, dec_mem_read, dec_mem_write, dec_halt, dec_is_lui, dec_use_imm;
  logic dec_use_rs, dec_use_rt, dec_is_beq, dec_is_j;
  logic [4:0] dec_dest;

  always_comb begin
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_halt      = 1'b0;
    dec_is_lui    = 1'b0;
    dec_use_imm   = 1'b0;
    dec_use_rs    = 1'b0;
    dec_use_rt    = 1'b0;
    dec_is_beq    = 1'b0;
    dec_is_j      = 1'b0;
    dec_dest      = 5'd0;
    case (id_op)
      OP_RTYPE: if (id_funct == FN_ADDU) begin
        dec_reg_write = 1'b1;
        dec_dest      = id_rd;
        dec_use_rs    = 1'b1;
        dec_use_rt    = 1'b1;
      end
      OP_ADDI: begin
        dec_reg_write = 1'b1;
        dec_dest      = id_rt;
        dec_use_imm   = 1'b1;
        dec_use_rs    = 1'b1;
      end
      OP_LUI: begin
        dec_reg_write = 1'b1;
        dec_dest      = id_rt;
        dec_is_lui    = 1'b1;
      end
      OP_LW: begin
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
        dec_dest      = id_rt;
        dec_use_imm   = 1'b1;
        dec_use_rs    = 1'b1;
      end
      OP_SW: begin
        dec_mem_write = 1'b1;
        dec_use_imm   = 1'b1;
        dec_use_rs    = 1'b1;
        dec_use_rt    = 1'b1;
      end
      OP_BEQ: begin
        dec_is_beq = 1'b1;
        dec_use_rs = 1'b1;
        dec_use_rt = 1'b1;
      end
      OP_J:    dec_is_j = 1'b1;
      OP_HALT: dec_halt = 1'b1;
      default: ;
    endcase
  end

  // Register read with same-cycle WB write-through
  logic [31:0] rs_val, rt_val;
  assign rs_val = (wb_active && memwb_q.dest == id_rs) ? wb_data : regs_q[id_rs];
  assign rt_val = (wb_active && memwb_q.dest == id_rt) ? wb_data : regs_q[id_rt];

  logic rs_hit_ex, rt_hit_ex, rs_hit_mem, rt_hit_mem;
  assign rs_hit_ex  = dec_use_rs && id_rs != 5'd0 && idex_q.reg_write && idex_q.dest == id_rs;
  assign rt_hit_ex  = dec_use_rt && id_rt != 5'd0 && idex_q.reg_write && idex_q.dest == id_rt;
  assign rs_hit_mem = dec_use_rs && id_rs != 5'd0 && exmem_q.reg_write && exmem_q.dest == id_rs;
  assign rt_hit_mem = dec_use_rt && id_rt != 5'd0 && exmem_q.reg_write && exmem_q.dest == id_rt;

  logic        stall;
  logic [31:0] cmp_a, cmp_b;
  always_comb begin
`ifdef FORWARDING_EN
    // Load data is only ready from MEM/WB, and BEQ compares in ID, so those cases still wait.
    stall = ((rs_hit_ex || rt_hit_ex) && (idex_q.mem_read || dec_is_beq))
         || (dec_is_beq && exmem_q.mem_read && (rs_hit_mem || rt_hit_mem));
    cmp_a = rs_hit_mem ? exmem_q.alu : rs_val;
    cmp_b = rt_hit_mem ? exmem_q.alu : rt_val;
`else
    stall = rs_hit_ex || rt_hit_ex || rs_hit_mem || rt_hit_mem;
    cmp_a = rs_val;
    cmp_b = rt_val;
`endif
  end

  logic                 redirect, fetch_off;
  logic [ADDRWIDTH-1:0] redirect_pc;
  assign redirect    = dec_is_j || (dec_is_beq && cmp_a == cmp_b);
  assign redirect_pc = dec_is_j ? id_instr[ADDRWIDTH-1:0]
                                : ifid_q.pc + ADDRWIDTH'(1) + id_imm[ADDRWIDTH-1:0];
  assign fetch_off   = ~i_en_read | halt_fetch_q | dec_halt;

  // Execute
  logic [31:0] ex_a, ex_b, ex_alu;
  always_comb begin
    ex_a = idex_q.a;
    ex_b = idex_q.b;
`ifdef FORWARDING_EN
    if (exmem_q.reg_write && exmem_q.dest != 5'd0 && exmem_q.dest == idex_q.rs) ex_a = exmem_q.alu;
    else if (wb_active && memwb_q.dest == idex_q.rs)                            ex_a = wb_data;
    if (exmem_q.reg_write && exmem_q.dest != 5'd0 && exmem_q.dest == idex_q.rt) ex_b = exmem_q.alu;
    else if (wb_active && memwb_q.dest == idex_q.rt)                            ex_b = wb_data;
`endif
    ex_alu = idex_q.is_lui ? {idex_q.imm[15:0], 16'h0000}
                           : ex_a + (idex_q.use_imm ? idex_q.imm : ex_b);
  end

  logic [ADDRWIDTH-1:0] mem_addr;
  logic                 dmem_we;
  assign mem_addr = exmem_q.alu[ADDRWIDTH-1:0];
  assign dmem_we  = adv && exmem_q.mem_write;

  always_comb begin
    ifid_d       = ifid_q;
    idex_d       = idex_q;
    exmem_d      = exmem_q;
    memwb_d      = memwb_q;
    pc_d         = pc_q;
    count_d      = count_q;
    halt_d       = halt_q;
    halt_fetch_d = halt_fetch_q;
    if (adv) begin
      count_d = count_q + ADDRWIDTH'(1);
      halt_d  = halt_q | memwb_q.halt;

      memwb_d.reg_write = exmem_q.reg_write;
      memwb_d.mem_read  = exmem_q.mem_read;
      memwb_d.halt      = exmem_q.halt;
      memwb_d.dest      = exmem_q.dest;
      memwb_d.alu       = exmem_q.alu;

      exmem_d.reg_write = idex_q.reg_write;
      exmem_d.mem_read  = idex_q.mem_read;
      exmem_d.mem_write = idex_q.mem_write;
      exmem_d.halt      = idex_q.halt;
      exmem_d.dest      = idex_q.dest;
      exmem_d.alu       = ex_alu;
      exmem_d.store     = ex_b;

      if (stall) begin
        idex_d = '0;
      end else begin
        idex_d.reg_write = dec_reg_write;
        idex_d.mem_read  = dec_mem_read;
        idex_d.mem_write = dec_mem_write;
        idex_d.halt      = dec_halt;
        idex_d.is_lui    = dec_is_lui;
        idex_d.use_imm   = dec_use_imm;
        idex_d.dest      = dec_dest;
        idex_d.rs        = id_rs;
        idex_d.rt        = id_rt;
        idex_d.a         = rs_val;
        idex_d.b         = rt_val;
        idex_d.imm       = id_imm;
        if (dec_halt) halt_fetch_d = 1'b1;
        if (redirect) begin
          pc_d   = redirect_pc;
          ifid_d = '0;
        end else if (fetch_off) begin
          ifid_d = '0;
        end else begin
          ifid_d.instr = imem[pc_q];
          ifid_d.pc    = pc_q;
          pc_d         = pc_q + ADDRWIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      pc_q         <= '0;
      count_q      <= '0;
      halt_q       <= 1'b0;
      halt_fetch_q <= 1'b0;
      ifid_q       <= '0;
      idex_q       <= '0;
      exmem_q      <= '0;
      memwb_q      <= '0;
    end else begin
      pc_q         <= pc_d;
      count_q      <= count_d;
      halt_q       <= halt_d;
      halt_fetch_q <= halt_fetch_d;
      ifid_q       <= ifid_d;
      idex_q       <= idex_d;
      exmem_q      <= exmem_d;
      memwb_q      <= memwb_d;
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int r = 0; r < 32; r++) regs_q[r] <= '0;
    end else if (wb_we) begin
      regs_q[memwb_q.dest] <= wb_data;
    end
  end

  // Memories keep their contents across reset so a loaded program survives it.
  always_ff @(posedge clock) begin
    if (i_debug_unit && i_en_write) imem[i_addr_inst_load] <= i_inst_load;
  end

  always_ff @(posedge clock) begin
    if (dmem_we) dmem[mem_addr] <= exmem_q.store;
    if (adv) load_data_q <= dmem[mem_addr];
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      dirty_q <= '0;
    end else begin
      if (i_ctrl_wr_debug_mem) dirty_q <= '0;
      if (dmem_we) dirty_q[mem_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      reg_dbg_q <= '0;
      mem_dbg_q <= '0;
    end else if (i_read_du) begin
      if (i_ctrl_read_debug_reg) reg_dbg_q <= regs_q[i_addr_debug_unit[4:0]];
      if (i_enable_mem && i_ctrl_addr_debug_mem) mem_dbg_q <= dmem[i_addr_mem_debug_unit];
    end
  end

  assign o_bit_sucio           = dirty_q[i_addr_mem_debug_unit];
  assign o_data_send_pc        = pc_q;
  assign o_data_reg_debug_unit = reg_dbg_q;
  assign o_data_mem_debug_unit = mem_dbg_q;
  assign o_count_cycles        = count_q;
  assign o_halt                = halt_q;

  logic unused_ok;
`ifdef FORWARDING_EN
  assign unused_ok = ^i_addr_debug_unit[ADDRWIDTH-1:5];
`else
  assign unused_ok = ^{i_addr_debug_unit[ADDRWIDTH-1:5], idex_q.rs, idex_q.rt};
`endif

endmodule

// File: tb/tb_mips_pipeline.sv
// Directed bench for mips_pipeline: loads small programs through the debug hooks and checks results.
module tb_mips_pipeline;
  logic        clock = 1'b0;
  logic        i_reset;
  logic [31:0] i_inst_load;
  logic [7:0]  i_addr_inst_load;
  logic        i_en_write, i_en_read, i_enable_mem, i_read_du, i_enable_pipe, i_debug_unit;
  logic [7:0]  i_addr_debug_unit, i_addr_mem_debug_unit;
  logic        i_ctrl_read_debug_reg, i_ctrl_wr_debug_mem, i_ctrl_addr_debug_mem;
  logic        o_bit_sucio, o_halt;
  logic [7:0]  o_data_send_pc, o_count_cycles;
  logic [31:0] o_data_reg_debug_unit, o_data_mem_debug_unit;

  mips_pipeline #(.ADDRWIDTH(8)) dut (
    .clock(clock), .i_reset(i_reset), .i_inst_load(i_inst_load),
    .i_addr_inst_load(i_addr_inst_load), .i_en_write(i_en_write), .i_en_read(i_en_read),
    .i_enable_mem(i_enable_mem), .i_read_du(i_read_du), .i_enable_pipe(i_enable_pipe),
    .i_debug_unit(i_debug_unit), .i_addr_debug_unit(i_addr_debug_unit),
    .i_addr_mem_debug_unit(i_addr_mem_debug_unit), .i_ctrl_read_debug_reg(i_ctrl_read_debug_reg),
    .i_ctrl_wr_debug_mem(i_ctrl_wr_debug_mem), .i_ctrl_addr_debug_mem(i_ctrl_addr_debug_mem),
    .o_bit_sucio(o_bit_sucio), .o_data_send_pc(o_data_send_pc),
    .o_data_reg_debug_unit(o_data_reg_debug_unit), .o_data_mem_debug_unit(o_data_mem_debug_unit),
    .o_count_cycles(o_count_cycles), .o_halt(o_halt)
  );

  always #5 clock = ~clock;

`ifdef FORWARDING_EN
  localparam int CNT0 = 8, CNT1 = 11, CNT2 = 10;
`else
  localparam int CNT0 = 10, CNT1 = 12, CNT2 = 13;
`endif
  localparam int CNT3 = 8;
  localparam int K_REG = 0, K_MEM = 1, K_DIRTY = 2, K_CNT = 3, K_HALT = 4;

  typedef struct {
    int          prog;
    int          kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs [32];
  int          nvec = 0;
  logic [31:0] prog_mem [4][8];
  logic [7:0]  pc_trace [$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] f_lui(input logic [4:0] rt, input logic [15:0] imm);
    return {6'h0F, 5'd0, rt, imm};
  endfunction
  function automatic logic [31:0] f_addu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, 6'h21};
  endfunction
  function automatic logic [31:0] f_addi(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
    return {6'h08, rs, rt, imm};
  endfunction
  function automatic logic [31:0] f_beq(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {6'h04, rs, rt, imm};
  endfunction
  function automatic logic [31:0] f_lw(input logic [4:0] rt, input logic [15:0] off, input logic [4:0] base);
    return {6'h23, base, rt, off};
  endfunction
  function automatic logic [31:0] f_sw(input logic [4:0] rt, input logic [15:0] off, input logic [4:0] base);
    return {6'h2B, base, rt, off};
  endfunction
  function automatic logic [31:0] f_j(input logic [25:0] target);
    return {6'h02, target};
  endfunction
  function automatic logic [31:0] f_halt();
    return {6'h3F, 26'd0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic add_vec(input int p, input int k, input int idx, input logic [31:0] e, input string n);
    vecs[nvec].prog = p;
    vecs[nvec].kind = k;
    vecs[nvec].idx  = idx;
    vecs[nvec].exp  = e;
    vecs[nvec].name = n;
    nvec++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    i_reset = 1'b0;
    @(negedge clock);
    i_reset = 1'b1;
  endtask

  task automatic load_prog(input int p);
    i_enable_pipe = 1'b0;
    i_debug_unit  = 1'b1;
    for (int a = 0; a < 16; a++) begin
      @(negedge clock);
      i_addr_inst_load = 8'(a);
      i_inst_load      = (a < 8) ? prog_mem[p][a] : 32'd0;
      i_en_write       = 1'b1;
    end
    @(negedge clock);
    i_en_write   = 1'b0;
    i_debug_unit = 1'b0;
  endtask

  task automatic step(input int n);
    i_enable_pipe = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      pc_trace.push_back(o_data_send_pc);
    end
    i_enable_pipe = 1'b0;
  endtask

  task automatic run_to_halt();
    pc_trace.push_back(o_data_send_pc);
    i_enable_pipe = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      pc_trace.push_back(o_data_send_pc);
      if (o_halt) break;
    end
    i_enable_pipe = 1'b0;
    check("halt_reached", 32'(o_halt), 32'd1);
  endtask

  task automatic read_reg(input int idx, output logic [31:0] v);
    i_addr_debug_unit     = 8'(idx);
    i_read_du             = 1'b1;
    i_ctrl_read_debug_reg = 1'b1;
    @(negedge clock);
    i_read_du             = 1'b0;
    i_ctrl_read_debug_reg = 1'b0;
    v = o_data_reg_debug_unit;
  endtask

  task automatic read_mem(input int idx, output logic [31:0] v);
    i_addr_mem_debug_unit = 8'(idx);
    i_read_du             = 1'b1;
    i_enable_mem          = 1'b1;
    i_ctrl_addr_debug_mem = 1'b1;
    @(negedge clock);
    i_read_du             = 1'b0;
    i_enable_mem          = 1'b0;
    i_ctrl_addr_debug_mem = 1'b0;
    v = o_data_mem_debug_unit;
  endtask

  task automatic fetch_actual(input int kind, input int idx, output logic [31:0] v);
    v = '0;
    case (kind)
      K_REG: read_reg(idx, v);
      K_MEM: read_mem(idx, v);
      K_DIRTY: begin
        i_addr_mem_debug_unit = 8'(idx);
        #1 v = 32'(o_bit_sucio);
      end
      K_CNT:  v = 32'(o_count_cycles);
      K_HALT: v = 32'(o_halt);
      default: v = '0;
    endcase
  endtask

  initial begin
    logic [31:0] act;
    i_reset = 1'b0; i_inst_load = '0; i_addr_inst_load = '0; i_en_write = 1'b0;
    i_en_read = 1'b1; i_enable_mem = 1'b0; i_read_du = 1'b0; i_enable_pipe = 1'b0;
    i_debug_unit = 1'b0; i_addr_debug_unit = '0; i_addr_mem_debug_unit = '0;
    i_ctrl_read_debug_reg = 1'b0; i_ctrl_wr_debug_mem = 1'b0; i_ctrl_addr_debug_mem = 1'b0;

    for (int p = 0; p < 4; p++) for (int a = 0; a < 8; a++) prog_mem[p][a] = 32'd0;
    prog_mem[0][0] = f_lui(1, 16'd10);  prog_mem[0][1] = f_lui(2, 16'd20);
    prog_mem[0][2] = f_addu(4, 1, 2);   prog_mem[0][3] = f_halt();
    prog_mem[1][0] = f_lui(3, 16'd30);  prog_mem[1][1] = f_lui(4, 16'd30);
    prog_mem[1][2] = f_beq(3, 4, 16'd1); prog_mem[1][3] = f_addi(5, 0, 16'd1);
    prog_mem[1][4] = f_addi(6, 0, 16'd2); prog_mem[1][5] = f_halt();
    prog_mem[2][0] = f_addi(1, 0, 16'd7); prog_mem[2][1] = f_sw(1, 16'd3, 0);
    prog_mem[2][2] = f_lw(2, 16'd3, 0);   prog_mem[2][3] = f_addu(3, 2, 2);
    prog_mem[2][4] = f_halt();
    prog_mem[3][0] = f_j(26'd3);          prog_mem[3][1] = f_addi(7, 0, 16'd9);
    prog_mem[3][2] = f_addi(9, 0, 16'd1); prog_mem[3][3] = f_addi(8, 0, 16'd5);
    prog_mem[3][4] = f_halt();

    add_vec(0, K_REG, 1, 32'h000A0000, "p0_r1");
    add_vec(0, K_REG, 2, 32'h00140000, "p0_r2");
    add_vec(0, K_REG, 4, 32'h001E0000, "p0_r4");
    add_vec(0, K_CNT, 0, 32'(CNT0), "p0_cycles");
    add_vec(0, K_HALT, 0, 32'd1, "p0_halt");
    add_vec(1, K_REG, 3, 32'h001E0000, "p1_r3");
    add_vec(1, K_REG, 5, 32'd0, "p1_r5_skipped");
    add_vec(1, K_REG, 6, 32'd2, "p1_r6");
    add_vec(1, K_CNT, 0, 32'(CNT1), "p1_cycles");
    add_vec(2, K_REG, 1, 32'd7, "p2_r1");
    add_vec(2, K_REG, 2, 32'd7, "p2_r2_load");
    add_vec(2, K_REG, 3, 32'd14, "p2_r3");
    add_vec(2, K_MEM, 3, 32'd7, "p2_dmem3");
    add_vec(2, K_DIRTY, 3, 32'd1, "p2_dirty3");
    add_vec(2, K_DIRTY, 4, 32'd0, "p2_dirty4");
    add_vec(2, K_CNT, 0, 32'(CNT2), "p2_cycles");
    add_vec(3, K_REG, 7, 32'd0, "p3_r7_flushed");
    add_vec(3, K_REG, 9, 32'd0, "p3_r9_skipped");
    add_vec(3, K_REG, 8, 32'd5, "p3_r8");
    add_vec(3, K_CNT, 0, 32'(CNT3), "p3_cycles");

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_pc", 32'(o_data_send_pc), 32'd0);
    check("rst_cycles", 32'(o_count_cycles), 32'd0);
    check("rst_halt", 32'(o_halt), 32'd0);
    check("rst_reg_dbg", o_data_reg_debug_unit, 32'd0);
    check("rst_mem_dbg", o_data_mem_debug_unit, 32'd0);
    i_reset = 1'b1;

    for (int p = 0; p < 4; p++) begin
      load_prog(p);
      do_reset();
      pc_trace.delete();
      run_to_halt();
      for (int v = 0; v < nvec; v++) begin
        if (vecs[v].prog == p) begin
          fetch_actual(vecs[v].kind, vecs[v].idx, act);
          check(vecs[v].name, act, vecs[v].exp);
        end
      end
      if (p == 2) begin
        @(negedge clock);
        i_ctrl_wr_debug_mem = 1'b1;
        @(negedge clock);
        i_ctrl_wr_debug_mem = 1'b0;
        i_addr_mem_debug_unit = 8'd3;
        #1 check("dirty_cleared", 32'(o_bit_sucio), 32'd0);
      end
      if (p == 3) begin
        check("j_pc0", 32'(pc_trace[0]), 32'd0);
        check("j_pc1", 32'(pc_trace[1]), 32'd1);
        check("j_pc2", 32'(pc_trace[2]), 32'd3);
        check("j_pc3", 32'(pc_trace[3]), 32'd4);
      end
    end

    // Reset asserted mid-run, then rerun the retained program
    load_prog(0);
    do_reset();
    step(5);
    read_reg(1, act);
    check("mid_r1_before", act, 32'h000A0000);
    @(negedge clock);
    i_reset = 1'b0;
    #1;
    check("mid_rst_pc", 32'(o_data_send_pc), 32'd0);
    check("mid_rst_cycles", 32'(o_count_cycles), 32'd0);
    check("mid_rst_halt", 32'(o_halt), 32'd0);
    check("mid_rst_reg_dbg", o_data_reg_debug_unit, 32'd0);
    @(negedge clock);
    i_reset = 1'b1;
    read_reg(1, act);
    check("mid_r1_cleared", act, 32'd0);
    run_to_halt();
    read_reg(4, act);
    check("rerun_r4", act, 32'h001E0000);
    check("rerun_cycles", 32'(o_count_cycles), 32'(CNT0));

    // Pipeline paused for 5 cycles mid-run
    do_reset();
    step(3);
    check("pause_pc_before", 32'(o_data_send_pc), 32'd3);
    check("pause_cnt_before", 32'(o_count_cycles), 32'd3);
    repeat (5) @(negedge clock);
    check("pause_pc_after", 32'(o_data_send_pc), 32'd3);
    check("pause_cnt_after", 32'(o_count_cycles), 32'd3);
    run_to_halt();
    read_reg(4, act);
    check("pause_r4", act, 32'h001E0000);
    check("pause_cycles", 32'(o_count_cycles), 32'(CNT0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_pipeline.md
# mips_pipeline

Five-stage (IF/ID/EX/MEM/WB) 32-bit MIPS-subset core with on-chip instruction memory, data memory and register file, plus debug-unit hooks. An external debug unit uses these hooks to load programs, start, step and halt the core, and read back state. This is the top-level execution block under the debug unit/UART controller.

## Interface
- `ADDRWIDTH`, 8: word-address width of IMEM, DMEM, PC and cycle counter (depth 2^ADDRWIDTH words each).
- `clock` in 1: single clock, rising edge.
- `i_reset` in 1: asynchronous, active-low reset.
- `i_inst_load` in 32: instruction word to load.
- `i_addr_inst_load` in ADDRWIDTH: IMEM load address (word).
- `i_en_write` in 1: IMEM write strobe (honoured only while `i_debug_unit`=1).
- `i_en_read` in 1: fetch enable; 0 makes IF inject NOP and hold PC.
- `i_enable_mem` in 1: enables DMEM debug read port.
- `i_read_du` in 1: capture strobe for both debug data outputs.
- `i_enable_pipe` in 1: run enable; pipeline advances only when 1.
- `i_debug_unit` in 1: load mode; pipeline frozen, IMEM owned by loader.
- `i_addr_debug_unit` in ADDRWIDTH: register index for debug read ([4:0] used).
- `i_addr_mem_debug_unit` in ADDRWIDTH: DMEM word address for debug read/dirty bit.
- `i_ctrl_read_debug_reg` in 1: enables register debug capture.
- `i_ctrl_wr_debug_mem` in 1: clears all DMEM dirty bits.
- `i_ctrl_addr_debug_mem` in 1: enables DMEM debug capture.
- `o_bit_sucio` out 1: dirty bit of DMEM word `i_addr_mem_debug_unit` (combinational).
- `o_data_send_pc` out ADDRWIDTH: current IF PC.
- `o_data_reg_debug_unit` out 32: captured register value.
- `o_data_mem_debug_unit` out 32: captured DMEM word.
- `o_count_cycles` out ADDRWIDTH: advanced-cycle counter.
- `o_halt` out 1: sticky halt flag.

## Operation
- Advance condition: `adv = i_enable_pipe & ~i_debug_unit & ~o_halt`. When `adv`=0, every stage register, PC and counter hold.
- IMEM: synchronous write at `i_addr_inst_load` when `i_debug_unit & i_en_write`. Asynchronous read at PC. Unloaded words are 0, which decodes as NOP.
- PC is a word address and increments by 1.
- Supported instructions:
  - LUI: rt = imm<<16.
  - ADDU: rd = rs+rt, wraps.
  - ADDI: rt = rs+sext(imm), no overflow trap.
  - BEQ: if rs==rt, PC = PC_branch+1+sext(imm).
  - J: PC = target[ADDRWIDTH-1:0].
  - LW: rt = DMEM[(rs+sext(imm))[ADDRWIDTH-1:0]].
  - SW: DMEM[...] = rt.
  - HALT: opcode 6'b111111.
  - Anything else: NOP.
- Branch and jump resolve in ID; the wrong-path IF instruction is flushed (1 bubble). BEQ compares forwarded operands.
- Load-use hazard: 1-cycle stall (PC and IF/ID hold, bubble into EX).
- Register file: 32×32. R0 reads 0 and ignores writes. A WB write is visible to an ID read in the same cycle.
- SW sets `dirty[addr]`. `i_ctrl_wr_debug_mem`=1 clears all dirty bits; a simultaneous SW still sets its bit.
- HALT decoded in ID freezes PC and fetches NOPs. Older instructions drain. `o_halt` sets when HALT reaches WB, then `adv`=0.
- Debug capture on a cycle with `i_read_du`=1:
  - `o_data_reg_debug_unit` loads `regs[i_addr_debug_unit[4:0]]` if `i_ctrl_read_debug_reg`.
  - `o_data_mem_debug_unit` loads `DMEM[i_addr_mem_debug_unit]` if `i_enable_mem & i_ctrl_addr_debug_mem`.
  - Otherwise each output holds.
- `o_count_cycles` increments on every `adv` cycle and wraps.

## Timing
- Reset (async, `i_reset`=0):
  - PC, all stage registers (NOP), register file, dirty bits, counter, `o_halt` and both debug outputs clear to 0.
  - IMEM and DMEM contents are preserved.
- ALU result: written back 4 advance cycles after fetch (WB is cycle 5).
- Debug outputs: valid one clock after the capture edge.
- `o_halt`: rises the edge HALT enters WB, i.e. 4 advance cycles after HALT is fetched (excluding stalls).
- Reset asserted mid-run: immediate return to PC=0, program retained.

## Configuration
- `FORWARDING_EN` defined: EX/MEM→EX and MEM/WB→EX forwarding, plus forwarding into ID for BEQ. Only load-use stalls, plus 1 extra stall when BEQ depends on the immediately preceding ALU result.
- `FORWARDING_EN` undefined: no bypass. ID stalls until every RAW-dependent producer has reached WB (same-cycle write-through still applies).

## Test plan
- Load `lui R1,10; lui R2,20; addu R4,R1,R2; halt`, run → R4=0x001E0000; `o_halt`=1; `o_count_cycles`=8 with FORWARDING_EN.
- `lui R3,30; lui R4,30; beq R3,R4,+1; addi R5,R0,1; addi R6,R0,2; halt` → R5=0 (skipped), R6=2.
- `addi R1,R0,7; sw R1,3(R0); lw R2,3(R0); addu R3,R2,R2; halt` → DMEM[3]=7, R3=14, one load-use stall; `o_bit_sucio`=1 at address 3, 0 at address 4.
- `j 3` at address 0 with `addi R7,R0,9` at address 1 → R7=0; PC sequence 0,1,3.
- Assert `i_reset`=0 mid-run → PC=0, registers 0, `o_halt`=0, IMEM intact; rerun gives identical results.
- `i_enable_pipe`=0 for 5 cycles mid-run → PC and `o_count_cycles` frozen; final results unchanged.
